// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//
// Fetch/decode/execute sequencer for the 8-bit computer. A Moore FSM whose
// states walk through instruction fetch (built around the one-clock registered
// program ROM read), decode, and the per-instruction execute sequence, driving
// every load/select/write strobe of the datapath.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low; forces FETCH_0 and zeroes outputs
//   IR          current instruction register contents (decoded in DECODE_3)
//   CCR_Result  {N,Z,V,C} flags, sampled in DECODE_3 for branch decisions
//   IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load  load strobes
//   ALU_Sel     0 ADD,1 SUB,2 AND,3 OR,4 INC,5 DEC,6 XOR,7 NOT
//   Bus1_Sel    0 PC, 1 A, 2 B
//   Bus2_Sel    0 ALU, 1 Bus1, 2 memory data
//   write       memory write of Bus1 to address MAR
// -----------------------------------------------------------------------------
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] IR,
    input  logic [3:0] CCR_Result,
    output logic       IR_Load,
    output logic       MAR_Load,
    output logic       PC_Load,
    output logic       PC_Inc,
    output logic       A_Load,
    output logic       B_Load,
    output logic [2:0] ALU_Sel,
    output logic       CCR_Load,
    output logic [1:0] Bus1_Sel,
    output logic [1:0] Bus2_Sel,
    output logic       write
);

    localparam logic [7:0] OP_LDA_IMM = 8'h86;
    localparam logic [7:0] OP_LDA_DIR = 8'h87;
    localparam logic [7:0] OP_LDB_IMM = 8'h88;
    localparam logic [7:0] OP_LDB_DIR = 8'h89;
    localparam logic [7:0] OP_STA_DIR = 8'h96;
    localparam logic [7:0] OP_STB_DIR = 8'h97;
    localparam logic [7:0] OP_ADD_AB  = 8'h42;
    localparam logic [7:0] OP_SUB_AB  = 8'h43;
    localparam logic [7:0] OP_AND_AB  = 8'h44;
    localparam logic [7:0] OP_OR_AB   = 8'h45;
    localparam logic [7:0] OP_INCA    = 8'h46;
    localparam logic [7:0] OP_INCB    = 8'h47;
    localparam logic [7:0] OP_DECA    = 8'h48;
    localparam logic [7:0] OP_DECB    = 8'h49;
    localparam logic [7:0] OP_XOR_AB  = 8'h4A;
    localparam logic [7:0] OP_NOTA    = 8'h4B;
    localparam logic [7:0] OP_NOTB    = 8'h4C;
    localparam logic [7:0] OP_BRA     = 8'h20;
    localparam logic [7:0] OP_BMI     = 8'h21;
    localparam logic [7:0] OP_BPL     = 8'h22;
    localparam logic [7:0] OP_BEQ     = 8'h23;
    localparam logic [7:0] OP_BNE     = 8'h24;
    localparam logic [7:0] OP_BVS     = 8'h25;
    localparam logic [7:0] OP_BVC     = 8'h26;
    localparam logic [7:0] OP_BCS     = 8'h27;
    localparam logic [7:0] OP_BCC     = 8'h28;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_INC = 3'd4;
    localparam logic [2:0] ALU_DEC = 3'd5;
    localparam logic [2:0] ALU_XOR = 3'd6;
    localparam logic [2:0] ALU_NOT = 3'd7;

    // Each ALU opcode has its own execute state so ALU_Sel and the
    // destination register are a pure function of the present state.
    typedef enum logic [5:0] {
        FETCH_0, FETCH_1, FETCH_2, DECODE_3,
        LDA_IMM_4, LDA_IMM_5, LDA_IMM_6,
        LDA_DIR_4, LDA_DIR_5, LDA_DIR_6, LDA_DIR_7, LDA_DIR_8,
        LDB_IMM_4, LDB_IMM_5, LDB_IMM_6,
        LDB_DIR_4, LDB_DIR_5, LDB_DIR_6, LDB_DIR_7, LDB_DIR_8,
        STA_DIR_4, STA_DIR_5, STA_DIR_6, STA_DIR_7,
        STB_DIR_4, STB_DIR_5, STB_DIR_6, STB_DIR_7,
        ADD_AB_4, SUB_AB_4, AND_AB_4, OR_AB_4,
        INCA_4, INCB_4, DECA_4, DECB_4,
        XOR_AB_4, NOTA_4, NOTB_4,
        BR_4, BR_5, BR_6, BR_SKIP
    } state_t;

    state_t state, state_next;
    logic   br_taken;

    wire flag_n = CCR_Result[3];
    wire flag_z = CCR_Result[2];
    wire flag_v = CCR_Result[1];
    wire flag_c = CCR_Result[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH_0;
        else        state <= state_next;
    end

    always_comb begin
        br_taken = 1'b0;
        case (IR)
            OP_BRA:  br_taken = 1'b1;
            OP_BMI:  br_taken = flag_n;
            OP_BPL:  br_taken = !flag_n;
            OP_BEQ:  br_taken = flag_z;
            OP_BNE:  br_taken = !flag_z;
            OP_BVS:  br_taken = flag_v;
            OP_BVC:  br_taken = !flag_v;
            OP_BCS:  br_taken = flag_c;
            OP_BCC:  br_taken = !flag_c;
            default: br_taken = 1'b0;
        endcase
    end

    // Next state. Terminal execute states and any illegal encoding fall
    // through to the default and return to FETCH_0.
    always_comb begin
        state_next = FETCH_0;
        case (state)
            FETCH_0:   state_next = FETCH_1;
            FETCH_1:   state_next = FETCH_2;
            FETCH_2:   state_next = DECODE_3;
            DECODE_3: begin
                case (IR)
                    OP_LDA_IMM: state_next = LDA_IMM_4;
                    OP_LDA_DIR: state_next = LDA_DIR_4;
                    OP_LDB_IMM: state_next = LDB_IMM_4;
                    OP_LDB_DIR: state_next = LDB_DIR_4;
                    OP_STA_DIR: state_next = STA_DIR_4;
                    OP_STB_DIR: state_next = STB_DIR_4;
                    OP_ADD_AB:  state_next = ADD_AB_4;
                    OP_SUB_AB:  state_next = SUB_AB_4;
                    OP_AND_AB:  state_next = AND_AB_4;
                    OP_OR_AB:   state_next = OR_AB_4;
                    OP_INCA:    state_next = INCA_4;
                    OP_INCB:    state_next = INCB_4;
                    OP_DECA:    state_next = DECA_4;
                    OP_DECB:    state_next = DECB_4;
                    OP_XOR_AB:  state_next = XOR_AB_4;
                    OP_NOTA:    state_next = NOTA_4;
                    OP_NOTB:    state_next = NOTB_4;
                    OP_BRA, OP_BMI, OP_BPL, OP_BEQ, OP_BNE,
                    OP_BVS, OP_BVC, OP_BCS, OP_BCC:
                        state_next = br_taken ? BR_4 : BR_SKIP;
                    default:    state_next = FETCH_0;
                endcase
            end
            LDA_IMM_4: state_next = LDA_IMM_5;
            LDA_IMM_5: state_next = LDA_IMM_6;
            LDA_DIR_4: state_next = LDA_DIR_5;
            LDA_DIR_5: state_next = LDA_DIR_6;
            LDA_DIR_6: state_next = LDA_DIR_7;
            LDA_DIR_7: state_next = LDA_DIR_8;
            LDB_IMM_4: state_next = LDB_IMM_5;
            LDB_IMM_5: state_next = LDB_IMM_6;
            LDB_DIR_4: state_next = LDB_DIR_5;
            LDB_DIR_5: state_next = LDB_DIR_6;
            LDB_DIR_6: state_next = LDB_DIR_7;
            LDB_DIR_7: state_next = LDB_DIR_8;
            STA_DIR_4: state_next = STA_DIR_5;
            STA_DIR_5: state_next = STA_DIR_6;
            STA_DIR_6: state_next = STA_DIR_7;
            STB_DIR_4: state_next = STB_DIR_5;
            STB_DIR_5: state_next = STB_DIR_6;
            STB_DIR_6: state_next = STB_DIR_7;
            BR_4:      state_next = BR_5;
            BR_5:      state_next = BR_6;
            default:   state_next = FETCH_0;
        endcase
    end

    // Moore outputs. Gated by reset so that nothing strobes while reset is
    // held, even though the state register already sits in FETCH_0.
    always_comb begin
        IR_Load  = 1'b0;
        MAR_Load = 1'b0;
        PC_Load  = 1'b0;
        PC_Inc   = 1'b0;
        A_Load   = 1'b0;
        B_Load   = 1'b0;
        ALU_Sel  = ALU_ADD;
        CCR_Load = 1'b0;
        Bus1_Sel = 2'd0;
        Bus2_Sel = 2'd0;
        write    = 1'b0;
        if (reset) begin
            case (state)
                // Address phase: PC onto Bus2 into MAR.
                FETCH_0, LDA_IMM_4, LDA_DIR_4, LDB_IMM_4, LDB_DIR_4,
                STA_DIR_4, STB_DIR_4, BR_4: begin
                    Bus1_Sel = 2'd0;
                    Bus2_Sel = 2'd1;
                    MAR_Load = 1'b1;
                end
                // ROM read edge; taken branches skip the increment (BR_5).
                FETCH_1, LDA_IMM_5, LDA_DIR_5, LDB_IMM_5, LDB_DIR_5,
                STA_DIR_5, STB_DIR_5, BR_SKIP: begin
                    PC_Inc = 1'b1;
                end
                FETCH_2: begin
                    Bus2_Sel = 2'd2;
                    IR_Load  = 1'b1;
                end
                LDA_IMM_6, LDA_DIR_8: begin
                    Bus2_Sel = 2'd2;
                    A_Load   = 1'b1;
                end
                LDB_IMM_6, LDB_DIR_8: begin
                    Bus2_Sel = 2'd2;
                    B_Load   = 1'b1;
                end
                // Operand byte is the direct address: reload MAR with it.
                LDA_DIR_6, LDB_DIR_6, STA_DIR_6, STB_DIR_6: begin
                    Bus2_Sel = 2'd2;
                    MAR_Load = 1'b1;
                end
                STA_DIR_7: begin
                    Bus1_Sel = 2'd1;
                    write    = 1'b1;
                end
                STB_DIR_7: begin
                    Bus1_Sel = 2'd2;
                    write    = 1'b1;
                end
                BR_6: begin
                    Bus2_Sel = 2'd2;
                    PC_Load  = 1'b1;
                end
                ADD_AB_4, SUB_AB_4, AND_AB_4, OR_AB_4, INCA_4, DECA_4,
                XOR_AB_4, NOTA_4: begin
                    Bus1_Sel = 2'd1;
                    Bus2_Sel = 2'd0;
                    A_Load   = 1'b1;
                    CCR_Load = 1'b1;
                end
                INCB_4, DECB_4, NOTB_4: begin
                    Bus1_Sel = 2'd2;
                    Bus2_Sel = 2'd0;
                    B_Load   = 1'b1;
                    CCR_Load = 1'b1;
                end
                default: ;
            endcase
            case (state)
                SUB_AB_4:         ALU_Sel = ALU_SUB;
                AND_AB_4:         ALU_Sel = ALU_AND;
                OR_AB_4:          ALU_Sel = ALU_OR;
                INCA_4, INCB_4:   ALU_Sel = ALU_INC;
                DECA_4, DECB_4:   ALU_Sel = ALU_DEC;
                XOR_AB_4:         ALU_Sel = ALU_XOR;
                NOTA_4, NOTB_4:   ALU_Sel = ALU_NOT;
                default:          ALU_Sel = ALU_ADD;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//
// Drives control_unit with directed and random instruction streams. A
// behavioural model turns (opcode, flags) into the expected per-cycle list of
// strobe vectors, starting at FETCH_0; the bench compares the DUT outputs
// against that list every cycle.
// -----------------------------------------------------------------------------
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] IR = 8'h00;
    logic [3:0] CCR_Result = 4'h0;
    logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load;
    logic [2:0] ALU_Sel;
    logic       CCR_Load;
    logic [1:0] Bus1_Sel, Bus2_Sel;
    logic       write;

    typedef struct packed {
        logic       ir_ld;
        logic       mar_ld;
        logic       pc_ld;
        logic       pc_inc;
        logic       a_ld;
        logic       b_ld;
        logic [2:0] alu;
        logic       ccr_ld;
        logic [1:0] b1;
        logic [1:0] b2;
        logic       wr;
    } vec_t;

    vec_t obs;
    vec_t exp_q[$];
    int   n_asrt = 0;
    int   n_fail = 0;

    logic [7:0] ops [26] = '{8'h86, 8'h87, 8'h88, 8'h89, 8'h96, 8'h97,
                             8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47,
                             8'h48, 8'h49, 8'h4A, 8'h4B, 8'h4C,
                             8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                             8'h26, 8'h27, 8'h28};

    control_unit dut (
        .clk        (clk),
        .reset      (reset),
        .IR         (IR),
        .CCR_Result (CCR_Result),
        .IR_Load    (IR_Load),
        .MAR_Load   (MAR_Load),
        .PC_Load    (PC_Load),
        .PC_Inc     (PC_Inc),
        .A_Load     (A_Load),
        .B_Load     (B_Load),
        .ALU_Sel    (ALU_Sel),
        .CCR_Load   (CCR_Load),
        .Bus1_Sel   (Bus1_Sel),
        .Bus2_Sel   (Bus2_Sel),
        .write      (write)
    );

    assign obs = {IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load,
                  ALU_Sel, CCR_Load, Bus1_Sel, Bus2_Sel, write};

    always #5 clk = ~clk;

    // Operand-address phase: PC -> MAR, then PC+1 (or an idle wait when a
    // branch is taken, since the target replaces PC).
    task automatic push_prefix(input bit taken_branch);
        vec_t x;
        x = '0; x.b2 = 2'd1; x.mar_ld = 1'b1; exp_q.push_back(x);
        x = '0; x.pc_inc = !taken_branch;      exp_q.push_back(x);
    endtask

    task automatic build(input logic [7:0] op, input logic [3:0] f);
        vec_t x;
        bit   is_b, taken;
        exp_q.delete();
        x = '0; x.b2 = 2'd1; x.mar_ld = 1'b1; exp_q.push_back(x);
        x = '0; x.pc_inc = 1'b1;               exp_q.push_back(x);
        x = '0; x.b2 = 2'd2; x.ir_ld = 1'b1;   exp_q.push_back(x);
        x = '0;                                exp_q.push_back(x);
        case (op)
            8'h86, 8'h88: begin
                push_prefix(1'b0);
                x = '0; x.b2 = 2'd2; x.a_ld = (op == 8'h86); x.b_ld = (op == 8'h88);
                exp_q.push_back(x);
            end
            8'h87, 8'h89: begin
                push_prefix(1'b0);
                x = '0; x.b2 = 2'd2; x.mar_ld = 1'b1; exp_q.push_back(x);
                x = '0;                              exp_q.push_back(x);
                x = '0; x.b2 = 2'd2; x.a_ld = (op == 8'h87); x.b_ld = (op == 8'h89);
                exp_q.push_back(x);
            end
            8'h96, 8'h97: begin
                push_prefix(1'b0);
                x = '0; x.b2 = 2'd2; x.mar_ld = 1'b1; exp_q.push_back(x);
                x = '0; x.wr = 1'b1; x.b1 = (op == 8'h96) ? 2'd1 : 2'd2;
                exp_q.push_back(x);
            end
            8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47,
            8'h48, 8'h49, 8'h4A, 8'h4B, 8'h4C: begin
                is_b = (op == 8'h47) || (op == 8'h49) || (op == 8'h4C);
                x = '0; x.b2 = 2'd0; x.ccr_ld = 1'b1;
                x.b1 = is_b ? 2'd2 : 2'd1;
                x.a_ld = !is_b; x.b_ld = is_b;
                case (op)
                    8'h42: x.alu = 3'd0;
                    8'h43: x.alu = 3'd1;
                    8'h44: x.alu = 3'd2;
                    8'h45: x.alu = 3'd3;
                    8'h46, 8'h47: x.alu = 3'd4;
                    8'h48, 8'h49: x.alu = 3'd5;
                    8'h4A: x.alu = 3'd6;
                    default: x.alu = 3'd7;
                endcase
                exp_q.push_back(x);
            end
            8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28: begin
                case (op)
                    8'h20: taken = 1'b1;
                    8'h21: taken = f[3];
                    8'h22: taken = !f[3];
                    8'h23: taken = f[2];
                    8'h24: taken = !f[2];
                    8'h25: taken = f[1];
                    8'h26: taken = !f[1];
                    8'h27: taken = f[0];
                    default: taken = !f[0];
                endcase
                if (taken) begin
                    push_prefix(1'b1);
                    x = '0; x.b2 = 2'd2; x.pc_ld = 1'b1; exp_q.push_back(x);
                end else begin
                    x = '0; x.pc_inc = 1'b1; exp_q.push_back(x);
                end
            end
            default: ;
        endcase
    endtask

    task automatic check(input string tag, input int cyc, input vec_t e);
        n_asrt++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s op=%02h ccr=%04b cyc=%0d got=%04h exp=%04h",
                   tag, IR, CCR_Result, cyc, obs, e);
        end
    endtask

    // Called at a falling edge in the FETCH_0 cycle. Checks up to `limit`
    // cycles; when the whole instruction is checked it leaves the bench at the
    // falling edge of the next instruction's FETCH_0 cycle, otherwise it stays
    // in the last checked cycle.
    task automatic run(input string tag, input logic [7:0] op,
                       input logic [3:0] f, input int limit);
        int n;
        build(op, f);
        IR = op;
        CCR_Result = f;
        n = (limit < exp_q.size()) ? limit : exp_q.size();
        for (int i = 0; i < n; i++) begin
            #1;
            check(tag, i + 1, exp_q[i]);
            if (i + 1 < n) @(negedge clk);
        end
        if (n == exp_q.size()) @(negedge clk);
    endtask

    initial begin
        vec_t zero;
        logic [7:0] op;
        zero = '0;

        // Reset held for three clocks: everything quiet.
        repeat (3) begin
            @(negedge clk);
            #1;
            check("reset_hold", 0, zero);
        end
        @(negedge clk);
        reset = 1'b1;

        run("lda_imm", 8'h86, 4'h0, 100);
        run("lda_dir", 8'h87, 4'h0, 100);
        run("sta_dir", 8'h96, 4'h0, 100);
        run("ldb_imm", 8'h88, 4'h0, 100);
        run("ldb_dir", 8'h89, 4'h0, 100);
        run("stb_dir", 8'h97, 4'h0, 100);
        run("add_ab",  8'h42, 4'h0, 100);
        run("decb",    8'h49, 4'h0, 100);
        run("beq_tkn", 8'h23, 4'b0100, 100);
        run("beq_not", 8'h23, 4'b0000, 100);
        run("undef",   8'hFF, 4'hF, 100);

        for (int o = 0; o < 9; o++) begin
            for (int f = 0; f < 16; f++) begin
                run("br_sweep", 8'h20 + 8'(o), 4'(f), 100);
            end
        end

        // Reset pulsed in the middle of a store, during the MAR reload cycle.
        run("sta_pre", 8'h96, 4'h0, 7);
        reset = 1'b0;
        #1;
        check("abort_now", 0, zero);
        repeat (2) begin
            @(negedge clk);
            #1;
            check("abort_hold", 0, zero);
        end
        @(negedge clk);
        reset = 1'b1;
        run("after_abort", 8'hFF, 4'h0, 100);

        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 3) == 0) op = 8'($urandom_range(0, 255));
            else                           op = ops[$urandom_range(0, 25)];
            run("random", op, 4'($urandom_range(0, 15)), 100);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Fetch/decode/execute sequencer for the 8-bit computer. It consumes the instruction byte captured from the 128x8 synchronous program ROM and drives every load, select and write strobe of the datapath: PC, MAR, IR, A, B, CCR, the two bus multiplexers, the ALU and the memory write enable. The state sequence is built around the ROM's one-clock registered read.

## Interface
- No parameters. Opcodes are fixed localparams equal to the shared instruction-set encoding given under Operation.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; low forces state FETCH_0 immediately.
- IR  in  8  current instruction register contents.
- CCR_Result  in  4  {N,Z,V,C} flags from the CCR.
- IR_Load  out  1  load IR from Bus2.
- MAR_Load  out  1  load MAR from Bus2.
- PC_Load  out  1  load PC from Bus2.
- PC_Inc  out  1  PC <= PC+1 (8-bit wrap).
- A_Load, B_Load  out  1 each  load register A or B from Bus2.
- ALU_Sel  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 INC, 5 DEC, 6 XOR, 7 NOT. In1 = Bus1, In2 = B. INC, DEC and NOT use In1 only.
- CCR_Load  out  1  capture ALU NZVC.
- Bus1_Sel  out  2  0 PC, 1 A, 2 B.
- Bus2_Sel  out  2  0 ALU, 1 Bus1, 2 memory data.
- write  out  1  memory write of Bus1 to address MAR.

## Operation
- Moore FSM. Outputs decode from the present state only.
- Any output not listed for a state is 0.
- While reset is low, all outputs are forced to 0.
- Opcode encoding:
  - Loads and stores: LDA_IMM 86, LDA_DIR 87, LDB_IMM 88, LDB_DIR 89, STA_DIR 96, STB_DIR 97.
  - ALU: ADD_AB 42, SUB_AB 43, AND_AB 44, OR_AB 45, INCA 46, INCB 47, DECA 48, DECB 49, XOR_AB 4A, NOTA 4B, NOTB 4C.
  - Branches: BRA 20, BMI 21, BPL 22, BEQ 23, BNE 24, BVS 25, BVC 26, BCS 27, BCC 28.
- Fetch:
  - FETCH_0: Bus1_Sel=0, Bus2_Sel=1, MAR_Load.
  - FETCH_1: PC_Inc. The ROM registers the instruction byte on this edge.
  - FETCH_2: Bus2_Sel=2, IR_Load.
  - DECODE_3: no strobes; next state selected from IR and CCR_Result.
- Operand fetch prefix, shared by IMM, DIR and taken-branch sequences:
  - X_4: Bus1_Sel=0, Bus2_Sel=1, MAR_Load.
  - X_5: PC_Inc. For a taken branch, X_5 is instead an idle wait state with no PC_Inc.
- Immediate loads (LDx_IMM): X_6 Bus2_Sel=2, A_Load or B_Load, then FETCH_0.
- Direct loads (LDx_DIR):
  - X_6: Bus2_Sel=2, MAR_Load.
  - X_7: wait for the memory read.
  - X_8: Bus2_Sel=2, A_Load or B_Load, then FETCH_0.
- Direct stores (STx_DIR):
  - X_6: Bus2_Sel=2, MAR_Load.
  - X_7: Bus1_Sel = 1 for A or 2 for B, write, then FETCH_0.
- ALU ops: one state ALU_4, then FETCH_0.
  - ALU_4 drives Bus2_Sel=0, CCR_Load and ALU_Sel per opcode.
  - Two-operand ops and A-ops: Bus1_Sel=1, A_Load.
  - INCB, DECB, NOTB: Bus1_Sel=2, B_Load.
- Branches:
  - Condition is evaluated in DECODE_3 from CCR_Result: N=bit3, Z=bit2, V=bit1, C=bit0.
  - BRA is always taken.
  - Taken: X_4, X_5 (wait), then BR_6 with Bus2_Sel=2, PC_Load, then FETCH_0.
  - Not taken: BR_SKIP with PC_Inc, then FETCH_0.
- Undefined opcode: DECODE_3 goes to FETCH_0 (NOP). The FSM never hangs.
- Illegal or unreachable state encodings go to FETCH_0 on the next edge.

## Timing
- Fetch plus decode takes 4 cycles. Total clocks per instruction, including fetch:
  - NOP: 4
  - ALU: 5
  - branch not taken: 5
  - LD_IMM: 7
  - branch taken: 7
  - ST_DIR: 8
  - LD_DIR: 9
- Memory read latency is one clock: data for the MAR loaded on edge k is valid on Bus2 (Bus2_Sel=2) during the cycle after edge k+1.
- CCR_Result is sampled only in DECODE_3. An ALU op's flags are visible to the immediately following branch because CCR_Load occurs 4+ cycles earlier.
- Reset asserted mid-instruction aborts it at once, with no partial write afterwards. First FETCH_0 strobes appear in the first cycle after reset deasserts.

## Test plan
- Reset: hold reset low for 3 clocks, release. All outputs are 0 during reset. Cycle 1 after release shows MAR_Load=1, Bus2_Sel=1, Bus1_Sel=0.
- LDA_IMM: IR=86 presented at FETCH_2. The exact strobe sequence is FETCH_0..DECODE_3, X_4, X_5, X_6 with A_Load at cycle 7, then MAR_Load at cycle 8.
- LDA_DIR then STA_DIR: IR=87 gives A_Load at cycle 9. IR=96 gives write=1 with Bus1_Sel=1 at cycle 8, exactly one cycle wide.
- ALU: IR=42 gives ALU_Sel=0, Bus1_Sel=1, Bus2_Sel=0, A_Load, CCR_Load at cycle 5. IR=49 gives ALU_Sel=5, Bus1_Sel=2, B_Load.
- Branches:
  - BEQ with CCR_Result=4'b0100: PC_Load at cycle 7, no PC_Inc at X_5.
  - BEQ with CCR_Result=0: PC_Inc at cycle 5, FETCH_0 at cycle 6.
  - Sweep all 9 branch opcodes against all 16 flag values.
- Corner cases:
  - IR=FF returns to FETCH_0 after 4 cycles with no strobes in DECODE_3.
  - Reset pulsed during STA X_6 yields no write pulse afterwards.
